// File: rtl/scarv_cop_pkg.sv
// Shared constants, decode-entry layout and feature-gating helper for the
// SCARV ISE coprocessor decode queue.
package scarv_cop_pkg;

    localparam logic [6:0] COP_OPCODE = 7'b0101011;

    localparam logic [3:0] ICLASS_PACKED_ARITH = 4'd0;
    localparam logic [3:0] ICLASS_TWIDDLE      = 4'd1;
    localparam logic [3:0] ICLASS_LOADSTORE    = 4'd2;
    localparam logic [3:0] ICLASS_RANDOM       = 4'd3;
    localparam logic [3:0] ICLASS_MOVE         = 4'd4;
    localparam logic [3:0] ICLASS_MP           = 4'd5;
    localparam logic [3:0] ICLASS_BITWISE      = 4'd6;
    localparam logic [3:0] ICLASS_LAST         = 4'd6;

    // Scatter/gather subclasses occupy the lowest LOADSTORE codes.
    localparam logic [4:0] SCLASS_SCATTER_B = 5'd0;
    localparam logic [4:0] SCLASS_SCATTER_H = 5'd1;
    localparam logic [4:0] SCLASS_GATHER_B  = 5'd2;
    localparam logic [4:0] SCLASS_GATHER_H  = 5'd3;

    localparam int MCCR_R   = 0;
    localparam int MCCR_MP  = 1;
    localparam int MCCR_SG  = 2;
    localparam int MCCR_P32 = 3;
    localparam int MCCR_P16 = 4;
    localparam int MCCR_P8  = 5;
    localparam int MCCR_P4  = 6;
    localparam int MCCR_P2  = 7;

    localparam logic [2:0] PW_32 = 3'd0;
    localparam logic [2:0] PW_16 = 3'd1;
    localparam logic [2:0] PW_8  = 3'd2;
    localparam logic [2:0] PW_4  = 3'd3;
    localparam logic [2:0] PW_2  = 3'd4;

    typedef struct packed {
        logic        exception;
        logic [3:0]  iclass;
        logic [4:0]  subclass;
        logic [2:0]  pw;
        logic [3:0]  crs1;
        logic [3:0]  crs2;
        logic [3:0]  crs3;
        logic [3:0]  crd;
        logic [3:0]  crd1;
        logic [3:0]  crd2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic        wb_h;
        logic        wb_b;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    function automatic logic mccr_disabled(input dec_t d, input logic [7:0] mccr);
        logic dis;
        dis = 1'b0;
        case (d.iclass)
            ICLASS_RANDOM:    dis = ~mccr[MCCR_R];
            ICLASS_MP:        dis = ~mccr[MCCR_MP];
            ICLASS_LOADSTORE: dis = (d.subclass <= SCLASS_GATHER_H) & ~mccr[MCCR_SG];
            ICLASS_PACKED_ARITH: begin
                case (d.pw)
                    PW_32:   dis = ~mccr[MCCR_P32];
                    PW_16:   dis = ~mccr[MCCR_P16];
                    PW_8:    dis = ~mccr[MCCR_P8];
                    PW_4:    dis = ~mccr[MCCR_P4];
                    PW_2:    dis = ~mccr[MCCR_P2];
                    default: dis = 1'b0;
                endcase
            end
            default:          dis = 1'b0;
        endcase
        return dis;
    endfunction

endpackage

// File: rtl/scarv_cop_dq_fifo.sv
// Generic in-order FIFO: DEPTH x W storage, wrapping pointers, occupancy
// count and a synchronous flush that beats push and pop.
module scarv_cop_dq_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_srst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    output logic                       o_ready,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_ready = (r_count < CW'(DEPTH));
    assign o_valid = (r_count != {CW{1'b0}});
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign w_push  = i_push & o_ready & ~i_srst;
    assign w_pop   = i_pop & o_valid & ~i_srst;

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_srst) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/scarv_cop_idecode.sv
// Combinational ISE decoder: splits a raw coprocessor encoding into fields
// and flags encodings that are not valid coprocessor instructions.
module scarv_cop_idecode
    import scarv_cop_pkg::*;
(
    input  logic [31:0] i_encoded,
    output dec_t        o_dec
);

    // Field extraction and structural legality check.
    always_comb begin
        o_dec          = '0;
        o_dec.iclass   = i_encoded[31:28];
        o_dec.subclass = i_encoded[27:23];
        o_dec.pw       = i_encoded[22:20];
        o_dec.crs1     = i_encoded[18:15];
        o_dec.crs2     = i_encoded[22:19];
        o_dec.crs3     = i_encoded[14:11];
        o_dec.crd      = i_encoded[10:7];
        o_dec.crd1     = {i_encoded[10:8], 1'b0};
        o_dec.crd2     = {i_encoded[10:8], 1'b1};
        o_dec.rd       = i_encoded[11:7];
        o_dec.rs1      = i_encoded[19:15];
        o_dec.imm      = {{20{i_encoded[31]}}, i_encoded[31:20]};
        o_dec.wb_h     = i_encoded[12];
        o_dec.wb_b     = i_encoded[13];
        o_dec.exception = (i_encoded[6:0] != COP_OPCODE)
                        | (o_dec.iclass > ICLASS_LAST)
                        | ((o_dec.iclass == ICLASS_PACKED_ARITH) & (o_dec.pw > PW_2));
    end

endmodule

// File: rtl/scarv_cop_idecode_q.sv
// Decode stage: decodes incoming coprocessor encodings, applies MCCR
// feature gating at push time and queues the result for dispatch.
module scarv_cop_idecode_q
    import scarv_cop_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       flush,
    input  logic [7:0]                 cfg_mccr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_encoded,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_exception,
    output logic [3:0]                 out_class,
    output logic [4:0]                 out_subclass,
    output logic [2:0]                 out_pw,
    output logic [3:0]                 out_crs1,
    output logic [3:0]                 out_crs2,
    output logic [3:0]                 out_crs3,
    output logic [3:0]                 out_crd,
    output logic [3:0]                 out_crd1,
    output logic [3:0]                 out_crd2,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [31:0]                out_imm,
    output logic                       out_wb_h,
    output logic                       out_wb_b,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int EW = DEC_W + TAG_W;

    dec_t          w_dec;
    dec_t          w_dec_gated;
    dec_t          w_head_dec;
    logic [EW-1:0] w_head;
    logic          w_fifo_ready;

    scarv_cop_idecode u_dec (
        .i_encoded (in_encoded),
        .o_dec     (w_dec)
    );

    // MCCR is folded in here so queued entries keep the enables seen at push.
    always_comb begin
        w_dec_gated           = w_dec;
        w_dec_gated.exception = w_dec.exception | mccr_disabled(w_dec, cfg_mccr);
    end

    scarv_cop_dq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk   (g_clk),
        .i_rst_n (g_resetn),
        .i_srst  (flush),
        .i_push  (in_valid),
        .i_data  ({in_tag, w_dec_gated}),
        .o_ready (w_fifo_ready),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_data  (w_head),
        .o_count (count)
    );

    assign in_ready      = w_fifo_ready & g_resetn;
    assign w_head_dec    = dec_t'(w_head[DEC_W-1:0]);
    assign out_tag       = w_head[EW-1:DEC_W];
    assign out_exception = w_head_dec.exception;
    assign out_class     = w_head_dec.iclass;
    assign out_subclass  = w_head_dec.subclass;
    assign out_pw        = w_head_dec.pw;
    assign out_crs1      = w_head_dec.crs1;
    assign out_crs2      = w_head_dec.crs2;
    assign out_crs3      = w_head_dec.crs3;
    assign out_crd       = w_head_dec.crd;
    assign out_crd1      = w_head_dec.crd1;
    assign out_crd2      = w_head_dec.crd2;
    assign out_rd        = w_head_dec.rd;
    assign out_rs1       = w_head_dec.rs1;
    assign out_imm       = w_head_dec.imm;
    assign out_wb_h      = w_head_dec.wb_h;
    assign out_wb_b      = w_head_dec.wb_b;

endmodule

// File: tb/tb_scarv_cop_idecode_q.sv
// Self-checking bench for scarv_cop_idecode_q: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_scarv_cop_idecode_q;

    localparam int DEPTH = 2;
    localparam int TAG_W = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic             g_clk      = 1'b0;
    logic             g_resetn   = 1'b1;
    logic             flush      = 1'b0;
    logic [7:0]       cfg_mccr   = 8'hFF;
    logic             in_valid   = 1'b0;
    logic [31:0]      in_encoded = 32'h0;
    logic [TAG_W-1:0] in_tag     = 8'h00;
    logic             out_ready  = 1'b0;
    logic             in_ready, out_valid, out_exception, out_wb_h, out_wb_b;
    logic [3:0]       out_class, out_crs1, out_crs2, out_crs3, out_crd, out_crd1, out_crd2;
    logic [4:0]       out_subclass, out_rd, out_rs1;
    logic [2:0]       out_pw;
    logic [31:0]      out_imm;
    logic [TAG_W-1:0] out_tag;
    logic [CW-1:0]    count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ex;
        logic [3:0]  cls;
        logic [4:0]  sub;
        logic [2:0]  pw;
        logic [3:0]  crs1, crs2, crs3, crd, crd1, crd2;
        logic [4:0]  rd, rs1;
        logic [31:0] imm;
        logic        wb_h, wb_b;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];

    scarv_cop_idecode_q #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .cfg_mccr(cfg_mccr),
        .in_valid(in_valid), .in_ready(in_ready), .in_encoded(in_encoded), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_exception(out_exception),
        .out_class(out_class), .out_subclass(out_subclass), .out_pw(out_pw),
        .out_crs1(out_crs1), .out_crs2(out_crs2), .out_crs3(out_crs3), .out_crd(out_crd),
        .out_crd1(out_crd1), .out_crd2(out_crd2), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_imm(out_imm), .out_wb_h(out_wb_h), .out_wb_b(out_wb_b), .out_tag(out_tag),
        .count(count)
    );

    always #5 g_clk = ~g_clk;

    // Reference decode: field positions and legality/gating rules as plain arithmetic.
    function automatic exp_t model(input logic [31:0] enc, input logic [7:0] m, input logic [7:0] tag);
        exp_t e;
        int   cls, sub, pw;
        bit   illegal, gated;
        cls = int'((enc >> 28) & 32'hF);
        sub = int'((enc >> 23) & 32'h1F);
        pw  = int'((enc >> 20) & 32'h7);
        illegal = ((enc & 32'h7F) != 32'h2B) || (cls > 6) || (cls == 0 && pw > 4);
        gated   = (cls == 3 && !m[0]) || (cls == 5 && !m[1]) || (cls == 2 && sub < 4 && !m[2])
               || (cls == 0 && pw <= 4 && !m[3 + pw]);
        e.ex   = illegal || gated;
        e.cls  = 4'(cls);
        e.sub  = 5'(sub);
        e.pw   = 3'(pw);
        e.crs1 = 4'((enc >> 15) & 32'hF);
        e.crs2 = 4'((enc >> 19) & 32'hF);
        e.crs3 = 4'((enc >> 11) & 32'hF);
        e.crd  = 4'((enc >> 7) & 32'hF);
        e.crd1 = 4'(((enc >> 8) & 32'h7) * 2);
        e.crd2 = 4'(((enc >> 8) & 32'h7) * 2 + 1);
        e.rd   = 5'((enc >> 7) & 32'h1F);
        e.rs1  = 5'((enc >> 15) & 32'h1F);
        e.imm  = 32'($signed(enc) >>> 20);
        e.wb_h = enc[12];
        e.wb_b = enc[13];
        e.tag  = tag;
        return e;
    endfunction

    function automatic logic [31:0] mkenc(input int cls, input int sub, input int pw, input int low);
        return {4'(cls), 5'(sub), 3'(pw), 13'(low), 7'h2B};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge g_clk);
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        if (q.size() != 0) begin
            chk("exception", 32'(out_exception), 32'(q[0].ex));
            chk("class", 32'(out_class), 32'(q[0].cls));
            chk("subclass", 32'(out_subclass), 32'(q[0].sub));
            chk("pw", 32'(out_pw), 32'(q[0].pw));
            chk("crs1", 32'(out_crs1), 32'(q[0].crs1));
            chk("crs2", 32'(out_crs2), 32'(q[0].crs2));
            chk("crs3", 32'(out_crs3), 32'(q[0].crs3));
            chk("crd", 32'(out_crd), 32'(q[0].crd));
            chk("crd1", 32'(out_crd1), 32'(q[0].crd1));
            chk("crd2", 32'(out_crd2), 32'(q[0].crd2));
            chk("rd", 32'(out_rd), 32'(q[0].rd));
            chk("rs1", 32'(out_rs1), 32'(q[0].rs1));
            chk("imm", out_imm, q[0].imm);
            chk("wb_h", 32'(out_wb_h), 32'(q[0].wb_h));
            chk("wb_b", 32'(out_wb_b), 32'(q[0].wb_b));
            chk("tag", 32'(out_tag), 32'(q[0].tag));
        end
    endtask

    task automatic edge_();
        bit push, pop;
        @(posedge g_clk);
        push = in_valid && (q.size() < DEPTH) && !flush;
        pop  = (q.size() != 0) && out_ready && !flush;
        if (flush) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(model(in_encoded, cfg_mccr, in_tag));
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        edge_();
    endtask

    task automatic drive(input logic v, input logic [31:0] enc, input logic [7:0] tag, input logic rdy);
        in_valid   = v;
        in_encoded = enc;
        in_tag     = tag;
        out_ready  = rdy;
    endtask

    initial begin
        #1 g_resetn = 1'b0;
        #10;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        g_resetn = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge g_clk); #1;

        // Fill and drain
        drive(1'b1, mkenc(4, 9, 1, 32'h1ABC), 8'h11, 1'b0); cycle();
        drive(1'b1, mkenc(6, 2, 3, 32'h0F0F), 8'h22, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b1);
        sample();
        chk("fill_count", 32'(count), 32'd2);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head", 32'(out_tag), 32'h11);
        edge_();
        sample();
        chk("drain_second", 32'(out_tag), 32'h22);
        edge_();
        sample();
        chk("drain_empty", 32'(count), 32'd0);
        edge_();
        out_ready = 1'b0;

        // Streaming at full throughput
        drive(1'b1, mkenc(1, 0, 0, 0), 8'd0, 1'b0); cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, mkenc(1, i, 0, i * 37), 8'(i + 1), 1'b1);
            sample();
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_tag", 32'(out_tag), 32'(i));
            edge_();
        end
        drive(1'b0, 32'h0, 8'h00, 1'b1); cycle(); cycle();
        out_ready = 1'b0;

        // MCCR gating
        cfg_mccr = 8'hFD;
        drive(1'b1, mkenc(5, 1, 0, 32'h0123), 8'h40, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b1);
        sample(); chk("gate_mp_off", 32'(out_exception), 32'd1); edge_();
        cfg_mccr = 8'hFF;
        drive(1'b1, mkenc(5, 1, 0, 32'h0123), 8'h41, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b1);
        sample(); chk("gate_mp_on", 32'(out_exception), 32'd0); edge_();
        cfg_mccr = 8'h7F;
        drive(1'b1, mkenc(0, 3, 4, 32'h0456), 8'h42, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b1);
        sample(); chk("gate_p2_off", 32'(out_exception), 32'd1); edge_();

        // MCCR sampled at push time
        cfg_mccr = 8'hFF;
        drive(1'b1, mkenc(5, 4, 2, 32'h0789), 8'h43, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b0);
        cfg_mccr = 8'h00;
        out_ready = 1'b1;
        sample(); chk("mccr_sampled", 32'(out_exception), 32'd0); edge_();
        out_ready = 1'b0;

        // Flush beats a simultaneous push and pop
        cfg_mccr = 8'hFF;
        drive(1'b1, mkenc(2, 7, 1, 32'h0AAA), 8'hAA, 1'b0); cycle();
        drive(1'b1, mkenc(2, 8, 1, 32'h0BBB), 8'hBB, 1'b0); cycle();
        drive(1'b1, mkenc(3, 0, 0, 32'h0333), 8'h33, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h00, 1'b1);
        sample();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        edge_();
        sample();
        chk("flush_no_33", 32'(out_valid), 32'd0);
        edge_();
        out_ready = 1'b0;

        // Asynchronous reset mid-stream
        drive(1'b1, mkenc(4, 1, 1, 32'h05A5), 8'h5A, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b0);
        #2 g_resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        #1 g_resetn = 1'b1;
        q.delete();
        #1;
        chk("mid_rel_count", 32'(count), 32'd0);
        @(posedge g_clk); #1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(31) == 0);
            cfg_mccr  = 8'($urandom);
            in_tag    = 8'($urandom);
            if ($urandom_range(7) == 0) in_encoded = $urandom;
            else in_encoded = mkenc($urandom_range(7), $urandom_range(9), $urandom_range(5), int'($urandom));
            cycle();
        end
        drive(1'b0, 32'h0, 8'h00, 1'b0);
        flush = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
